// File: rtl/aftab_bridge_pkg.sv
// Shared types and constants for the byte-to-word memory bridge.
package aftab_bridge_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } bridgeState_t;

    // One-hot lane enable for a byte offset within a word.
    function automatic logic [LANES-1:0] laneEnable(input logic [1:0] sel);
        return LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/aftab_register.sv
// Loadable register with synchronous active-high clear.
module aftab_register #(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld,
    input  logic [size-1:0] d,
    output logic [size-1:0] q
);

    // Clear on reset, otherwise capture d when ld is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/aftab_byte_mem_bridge.sv
// Bridges byte requests from the alignment units onto a word memory,
// keeping a single-word read buffer with write-through updates.
module aftab_byte_mem_bridge
    import aftab_bridge_pkg::*;
#(
    parameter int unsigned size = 4 * LANE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [size-1:0]       byteAddr,
    input  logic                  readMem,
    input  logic                  writeMem,
    input  logic [size/4-1:0]     byteDataIn,
    input  logic                  invalidate,
    output logic [size/4-1:0]     byteDataOut,
    output logic                  memReady,
    output logic [size-1:0]       wordAddr,
    output logic                  wordRead,
    output logic                  wordWrite,
    output logic [3:0]            wordByteEn,
    output logic [size-1:0]       wordDataOut,
    input  logic [size-1:0]       wordDataIn,
    input  logic                  wordAck
);

    localparam int unsigned laneW = size / LANES;
    localparam int unsigned tagW  = size - 2;

    bridgeState_t state, nextState;

    logic [size-1:0]  addrQ;
    logic [laneW-1:0] dataQ;
    logic [tagW-1:0]  tagQ;
    logic [size-1:0]  bufQ;
    logic [size-1:0]  bufD;
    logic             addrLd;
    logic             bufLd;
    logic             tagLd;
    logic             valid;
    logic             readHit;
    logic             writeHit;
    logic [size-1:0]  curAddr;
    logic [laneW-1:0] curData;
    logic [size-1:0]  selWord;
    logic [laneW-1:0] laneByte;

    aftab_register #(.size(size)) addrReg (
        .clk(clk), .rst(rst), .ld(addrLd), .d(byteAddr), .q(addrQ)
    );

    aftab_register #(.size(laneW)) dataReg (
        .clk(clk), .rst(rst), .ld(addrLd), .d(byteDataIn), .q(dataQ)
    );

    aftab_register #(.size(tagW)) tagReg (
        .clk(clk), .rst(rst), .ld(tagLd), .d(addrQ[size-1:2]), .q(tagQ)
    );

    aftab_register #(.size(size)) bufReg (
        .clk(clk), .rst(rst), .ld(bufLd), .d(bufD), .q(bufQ)
    );

    assign readHit  = valid && (tagQ == byteAddr[size-1:2]);
    assign writeHit = valid && (tagQ == addrQ[size-1:2]);

    // In IDLE the live request is used so strobes can start the next cycle.
    always_comb begin
        curAddr = addrQ;
        curData = dataQ;
        selWord = bufQ;
        if (state == IDLE) begin
            curAddr = byteAddr;
            curData = byteDataIn;
        end
        if (state == RD_WAIT) begin
            selWord = wordDataIn;
        end
    end

    // Little-endian 4:1 byte select.
    always_comb begin
        laneByte = '0;
        case (curAddr[1:0])
            2'd0:    laneByte = selWord[0*laneW +: laneW];
            2'd1:    laneByte = selWord[1*laneW +: laneW];
            2'd2:    laneByte = selWord[2*laneW +: laneW];
            default: laneByte = selWord[3*laneW +: laneW];
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state, latch enables and buffer update.
    always_comb begin
        nextState = state;
        addrLd    = 1'b0;
        bufLd     = 1'b0;
        tagLd     = 1'b0;
        bufD      = bufQ;
        case (state)
            IDLE: begin
                if (writeMem) begin
                    addrLd    = 1'b1;
                    nextState = WR_WAIT;
                end else if (readMem) begin
                    addrLd    = 1'b1;
                    nextState = readHit ? RESP : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wordAck) begin
                    bufLd     = 1'b1;
                    tagLd     = 1'b1;
                    bufD      = wordDataIn;
                    nextState = RESP;
                end
            end
            WR_WAIT: begin
                if (wordAck) begin
                    nextState = RESP;
                    if (writeHit) begin
                        bufLd = 1'b1;
                        for (int unsigned i = 0; i < LANES; i++) begin
                            if (addrQ[1:0] == 2'(i)) begin
                                bufD[i*laneW +: laneW] = dataQ;
                            end
                        end
                    end
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Buffer valid bit; invalidate always wins over a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (invalidate) begin
            valid <= 1'b0;
        end else if (state == RD_WAIT && wordAck) begin
            valid <= 1'b1;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            memReady    <= 1'b0;
            byteDataOut <= '0;
            wordRead    <= 1'b0;
            wordWrite   <= 1'b0;
            wordAddr    <= '0;
            wordByteEn  <= '0;
            wordDataOut <= '0;
        end else begin
            memReady  <= (nextState == RESP);
            wordRead  <= (nextState == RD_WAIT);
            wordWrite <= (nextState == WR_WAIT);
            if (nextState == RESP && state != WR_WAIT) begin
                byteDataOut <= laneByte;
            end
            if (nextState == RD_WAIT || nextState == WR_WAIT) begin
                wordAddr <= {curAddr[size-1:2], 2'b00};
            end else begin
                wordAddr <= '0;
            end
            if (nextState == WR_WAIT) begin
                wordByteEn  <= laneEnable(curAddr[1:0]);
                wordDataOut <= {LANES{curData}};
            end else begin
                wordByteEn  <= '0;
                wordDataOut <= '0;
            end
        end
    end

endmodule

// File: doc/aftab_byte_mem_bridge.md
AFTAB_BYTE_MEM_BRIDGE -- requirements
Module: aftab_byte_mem_bridge

Interface
REQ-001 Parameter: size, 32, data/address width; byte lane width is size/4 (8).
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 byteAddr  in  size  byte address from the alignment units (DARU addrOut / DAWU).
REQ-005 readMem  in  1  byte read request; held by requester until memReady.
REQ-006 writeMem  in  1  byte write request; held by requester until memReady.
REQ-007 byteDataIn  in  size/4  write byte.
REQ-008 invalidate  in  1  one-cycle pulse; clears word buffer valid bit.
REQ-009 byteDataOut  out  size/4  read byte (registered), feeds DARU memData.
REQ-010 memReady  out  1  one-cycle completion pulse for read or write.
REQ-011 wordAddr  out  size  word-aligned address {byteAddr[size-1:2], 2'b00}.
REQ-012 wordRead / wordWrite  out  1 each  word memory strobes, held until wordAck.
REQ-013 wordByteEn  out  4  write lane enables, one-hot from byteAddr[1:0].
REQ-014 wordDataOut  out  size  write data, byteDataIn replicated to all four lanes.
REQ-015 wordDataIn  in  size  read word; valid in the cycle wordAck is high.
REQ-016 wordAck  in  1  word memory completion, one cycle, arbitrary wait states (>=1 cycle after strobe).

Function
REQ-017 FSM states IDLE, RD_WAIT, WR_WAIT, RESP; only IDLE samples requests.
REQ-018 IDLE: latch byteAddr/byteDataIn into internal registers when readMem or writeMem is high.
REQ-019 readMem and writeMem both high: writeMem wins; read is not performed.
REQ-020 Read hit (valid and tag==byteAddr[size-1:2]): go directly to RESP; no word strobe; memReady one cycle after acceptance.
REQ-021 Read miss: RD_WAIT; on wordAck capture wordDataIn into buffer, tag, set valid, go RESP.
REQ-022 Write: WR_WAIT; on wordAck go RESP; if tag hit, update buffer byte lane addr[1:0] with byteDataIn (write-through).
REQ-023 RESP: memReady=1 for exactly one cycle; byteDataOut = buffer byte addr[1:0] (reads) or unchanged (writes); next state IDLE.
REQ-024 Requester changes or drops its request in the cycle after memReady; IDLE in that cycle samples the new request (back-to-back hits: one memReady every 2 cycles).
REQ-025 Strobes, wordAddr, wordByteEn, wordDataOut are driven only in RD_WAIT/WR_WAIT; zero otherwise.
REQ-026 invalidate clears valid in any state; if coincident with wordAck in RD_WAIT the byte is still returned but valid stays 0.
REQ-027 Byte lane select: lane i = bits [8i+7:8i], matching DARU byte ordering (little-endian).

Reset
REQ-028 rst: state IDLE, valid=0, tag=0, buffer=0, byteDataOut=0, memReady=0, all word-side outputs 0.
REQ-029 rst mid-transaction abandons it; no memReady issued; a later wordAck in IDLE is ignored.

Structure
REQ-030 Package aftab_bridge_pkg holds FSM state encoding and lane-width constant.
REQ-031 Buffer, tag and address latches use aftab_register; byte select is a local 4:1 mux.

Verification
REQ-032 Reset, read 0x100 miss, wordAck after 3 cycles with 0xDDCCBBAA -> wordRead 0x100 held 3 cycles, memReady, byteDataOut=0xAA.
REQ-033 Then reads 0x101,0x102,0x103 -> no wordRead, byteDataOut 0xBB,0xCC,0xDD, memReady every 2 cycles.
REQ-034 Write 0x55 to 0x102 -> wordByteEn=0100, wordDataOut=0x55555555; subsequent read 0x102 hits, returns 0x55.
REQ-035 readMem and writeMem both high at 0x200 -> only wordWrite asserted.
REQ-036 invalidate then read 0x100 -> miss, wordRead reissued.
REQ-037 rst during RD_WAIT, then wordAck -> no memReady, state IDLE, valid=0.
